// File: rtl/kamus_pipe_ctrl.sv
// kamus-v IF/ID/EX sequencing: redirect flush, load-use stall and the FENCE.I drain/invalidate/refetch sequence.
// Optional perf counters are built only when KAMUS_PIPE_PERF_EN is defined.
module kamus_pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic        id_fence_i_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_redirect_i,
  input  logic        l1d_busy_i,
  output logic        if_stall_o,
  output logic        id_stall_o,
  output logic        id_flush_o,
  output logic        ex_bubble_o,
  output logic        icache_inv_o,
  output logic        refetch_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_INV     = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use, fence_req;
  logic if_stall, id_stall, id_flush, ex_bubble, icache_inv, refetch;

  assign load_use = id_valid_i & ex_valid_i & ex_is_load_i & (ex_rd_addr_i != 5'd0) &
                    ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                     (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));
  assign fence_req = id_valid_i & id_fence_i_i;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    id_flush   = 1'b0;
    ex_bubble  = 1'b0;
    icache_inv = 1'b0;
    refetch    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (ex_redirect_i) begin
          id_flush  = 1'b1;
          ex_bubble = 1'b1;
        end else if (load_use) begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
        end else if (fence_req) begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
          cnt_d     = CNT_W'(DRAIN_CYCLES - 1);
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ex_redirect_i) begin
          // A redirect kills the fence itself, so the sequence is abandoned.
          id_flush  = 1'b1;
          ex_bubble = 1'b1;
          state_d   = ST_RUN;
        end else begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (!l1d_busy_i) begin
            state_d = ST_INV;
          end
        end
      end
      ST_INV: begin
        if (ex_redirect_i) begin
          id_flush  = 1'b1;
          ex_bubble = 1'b1;
        end else begin
          icache_inv = 1'b1;
          refetch    = 1'b1;
          if_stall   = 1'b1;
        end
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: reset is synchronous, so rst_ni stays out of the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are masked while reset is held so nothing leaks before the first edge.
  assign if_stall_o   = rst_ni & if_stall;
  assign id_stall_o   = rst_ni & id_stall;
  assign id_flush_o   = rst_ni & id_flush;
  assign ex_bubble_o  = rst_ni & ex_bubble;
  assign icache_inv_o = rst_ni & icache_inv;
  assign refetch_o    = rst_ni & refetch;
  assign state_o      = rst_ni ? state_q : 2'd0;

`ifdef KAMUS_PIPE_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_q + 32'(id_stall_o);
      flush_count_q  <= flush_count_q + 32'(id_flush_o);
    end
  end

  assign stall_cycles_o = rst_ni ? stall_cycles_q : 32'd0;
  assign flush_count_o  = rst_ni ? flush_count_q : 32'd0;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_count_o  = 32'd0;
`endif

endmodule

// File: tb/tb_kamus_pipe_ctrl.sv
// Self-checking bench for kamus_pipe_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the sequencing rules.
module tb_kamus_pipe_ctrl;

  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, rs1_used, rs2_used, id_fence;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd;
  logic        ex_valid, ex_load, redirect, busy;
  logic        if_stall, id_stall, id_flush, ex_bubble, icache_inv, refetch;
  logic [1:0]  state;
  logic [31:0] stall_cycles, flush_count;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0=run, 1=drain, 2=invalidate; drain_n counts drain cycles so far.
  int          m_phase   = 0;
  int          m_drain_n = 0;
  logic [31:0] m_stalls  = '0;
  logic [31:0] m_flushes = '0;

  kamus_pipe_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used), .id_fence_i_i(id_fence),
    .ex_valid_i(ex_valid), .ex_is_load_i(ex_load), .ex_rd_addr_i(ex_rd),
    .ex_redirect_i(redirect), .l1d_busy_i(busy),
    .if_stall_o(if_stall), .id_stall_o(id_stall), .id_flush_o(id_flush),
    .ex_bubble_o(ex_bubble), .icache_inv_o(icache_inv), .refetch_o(refetch),
    .state_o(state), .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic m_load_use();
    return id_valid && ex_valid && ex_load && ex_rd != 0 &&
           ((rs1_used && rs1_addr == ex_rd) || (rs2_used && rs2_addr == ex_rd));
  endfunction

  // {if_stall, id_stall, id_flush, ex_bubble, icache_inv, refetch, state[1:0]}
  function automatic logic [7:0] exp_ctrl();
    logic e_if, e_id, e_fl, e_bb, e_inv, e_rf;
    {e_if, e_id, e_fl, e_bb, e_inv, e_rf} = 6'b0;
    if (!rst_n) return 8'h00;
    if (redirect) begin
      e_fl = 1'b1; e_bb = 1'b1;
    end else if (m_phase == 0) begin
      if (m_load_use() || (id_valid && id_fence)) {e_if, e_id, e_bb} = 3'b111;
    end else if (m_phase == 1) begin
      {e_if, e_id, e_bb} = 3'b111;
    end else begin
      e_inv = 1'b1; e_rf = 1'b1; e_if = 1'b1;
    end
    return {e_if, e_id, e_fl, e_bb, e_inv, e_rf, 2'(m_phase)};
  endfunction

  function automatic logic [71:0] exp_all();
    logic [31:0] s, f;
`ifdef KAMUS_PIPE_PERF_EN
    s = rst_n ? m_stalls : 32'd0;
    f = rst_n ? m_flushes : 32'd0;
`else
    s = 32'd0;
    f = 32'd0;
`endif
    return {exp_ctrl(), s, f};
  endfunction

  function automatic logic [71:0] obs_all();
    return {if_stall, id_stall, id_flush, ex_bubble, icache_inv, refetch, state,
            stall_cycles, flush_count};
  endfunction

  task automatic model_advance();
    logic [7:0] e;
    e = exp_ctrl();
    if (!rst_n) begin
      m_phase = 0; m_drain_n = 0; m_stalls = '0; m_flushes = '0;
      return;
    end
    m_stalls  = m_stalls + 32'(e[6]);
    m_flushes = m_flushes + 32'(e[5]);
    if (redirect) m_phase = 0;
    else case (m_phase)
      0: if (!m_load_use() && id_valid && id_fence) begin m_phase = 1; m_drain_n = 1; end
      1: if (m_drain_n >= DC && !busy) m_phase = 2; else m_drain_n++;
      default: m_phase = 0;
    endcase
  endtask

  task automatic edge_adv();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0; id_fence = 0;
    ex_valid = 0; ex_load = 0; ex_rd = 0; redirect = 0; busy = 0;
  endtask

  task automatic set_fence();
    set_idle();
    id_valid = 1; id_fence = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      {id_valid, rs1_used, rs2_used, id_fence, ex_valid, ex_load, redirect, busy} = 8'($urandom);
      rs1_addr = 5'($urandom); rs2_addr = rs1_addr; ex_rd = rs1_addr;
      @(negedge clk);
      checks++;
      if (obs_all() !== 72'd0) begin
        failures++; $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, obs_all());
      end
      edge_adv();
    end
    set_idle(); rst_n = 1;
    @(negedge clk);
    checks++;
    if (obs_all() !== 72'd0) begin
      failures++; $display("FAIL reset_release got=%h exp=0", obs_all());
    end
    edge_adv();
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 2; k++) begin
      set_idle();
      ex_valid = 1; ex_load = 1; ex_rd = (k == 0) ? 5'd5 : 5'd0;
      id_valid = 1; rs1_used = 1; rs1_addr = 5'd7; rs2_used = 1; rs2_addr = ex_rd;
      @(negedge clk);
      checks++;
      if ({if_stall, id_stall, ex_bubble} !== ((k == 0) ? 3'b111 : 3'b000)) begin
        failures++; $display("FAIL load_use rd=%0d got=%b", ex_rd, {if_stall, id_stall, ex_bubble});
      end
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++; $display("FAIL load_use_model got=%h exp=%h", obs_all(), exp_all());
      end
      edge_adv();
      ex_valid = 0; ex_load = 0;
      @(negedge clk);
      checks++;
      if ({if_stall, id_stall, ex_bubble, id_flush} !== 4'b0000) begin
        failures++; $display("FAIL load_use_release got=%b exp=0000", {if_stall, id_stall, ex_bubble, id_flush});
      end
      edge_adv();
    end
  endtask

  task automatic test_redirect_hazard();
    logic [31:0] f0;
    set_idle();
    ex_valid = 1; ex_load = 1; ex_rd = 5'd9; id_valid = 1; rs1_used = 1; rs1_addr = 5'd9;
    redirect = 1;
    @(negedge clk);
    f0 = flush_count;
    checks++;
    if ({id_flush, ex_bubble, if_stall, id_stall} !== 4'b1100) begin
      failures++; $display("FAIL redirect_hazard got=%b exp=1100", {id_flush, ex_bubble, if_stall, id_stall});
    end
    edge_adv();
    set_idle();
    @(negedge clk);
    checks++;
`ifdef KAMUS_PIPE_PERF_EN
    if (flush_count !== f0 + 32'd1) begin
      failures++; $display("FAIL redirect_flush_count got=%0d exp=%0d", flush_count, f0 + 32'd1);
    end
`else
    if (flush_count !== 32'd0) begin
      failures++; $display("FAIL redirect_flush_count got=%0d exp=0", flush_count);
    end
`endif
    edge_adv();
  endtask

  task automatic test_fence();
    logic [1:0]  seq [6];
    logic [1:0]  want [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
    logic [31:0] s0;
    int          inv_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_fence(); else set_idle();
      @(negedge clk);
      if (i == 0) s0 = stall_cycles;
      seq[i] = state;
      inv_n += int'(icache_inv);
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++; $display("FAIL fence_model cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
      edge_adv();
    end
    checks++;
    if (seq !== want) begin
      failures++;
      $display("FAIL fence_states got=%0d%0d%0d%0d%0d%0d exp=011120",
               seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]);
    end
    checks++;
    if (inv_n != 1) begin
      failures++; $display("FAIL fence_inv_pulses got=%0d exp=1", inv_n);
    end
    @(negedge clk);
    checks++;
`ifdef KAMUS_PIPE_PERF_EN
    if (stall_cycles !== s0 + 32'd4) begin
      failures++; $display("FAIL fence_stall_count got=%0d exp=%0d", stall_cycles, s0 + 32'd4);
    end
`else
    if (stall_cycles !== 32'd0) begin
      failures++; $display("FAIL fence_stall_count got=%0d exp=0", stall_cycles);
    end
`endif
    edge_adv();
  endtask

  task automatic test_fence_busy();
    int drain_n = 0;
    int inv_at  = -1;
    for (int i = 0; i < 11; i++) begin
      if (i == 0) set_fence(); else set_idle();
      busy = (i >= 1 && i <= 7);
      @(negedge clk);
      drain_n += int'(state == 2'd1);
      if (icache_inv && inv_at < 0) inv_at = i;
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++; $display("FAIL fence_busy_model cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
      edge_adv();
    end
    checks++;
    if (drain_n != 8 || inv_at != 9) begin
      failures++; $display("FAIL fence_busy_drain got=%0d/%0d exp=8/9", drain_n, inv_at);
    end
  endtask

  task automatic test_redirect_drain();
    int inv_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_fence(); else set_idle();
      redirect = (i == 2);
      @(negedge clk);
      inv_n += int'(icache_inv | refetch);
      if (i == 2) begin
        checks++;
        if ({id_flush, ex_bubble, if_stall} !== 3'b110) begin
          failures++; $display("FAIL redirect_drain got=%b exp=110", {id_flush, ex_bubble, if_stall});
        end
      end
      if (i == 3) begin
        checks++;
        if (state !== 2'd0) begin
          failures++; $display("FAIL redirect_drain_state got=%0d exp=0", state);
        end
      end
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++; $display("FAIL redirect_drain_model cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
      edge_adv();
    end
    checks++;
    if (inv_n != 0) begin
      failures++; $display("FAIL redirect_drain_inv got=%0d exp=0", inv_n);
    end
  endtask

  task automatic test_reset_inv();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_fence(); else set_idle();
      rst_n = (i != 4);
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (obs_all() !== 72'd0) begin
          failures++; $display("FAIL reset_inv_outputs got=%h exp=0", obs_all());
        end
      end
      if (i == 5) begin
        checks++;
        if ({state, icache_inv, stall_cycles, flush_count} !== 67'd0) begin
          failures++; $display("FAIL reset_inv_after got=%0d/%b/%0d/%0d exp=0",
                               state, icache_inv, stall_cycles, flush_count);
        end
      end
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++; $display("FAIL reset_inv_model cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
      edge_adv();
    end
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      id_valid = ($urandom_range(0, 3) != 0);
      rs1_used = $urandom_range(0, 1);
      rs2_used = $urandom_range(0, 1);
      rs1_addr = 5'($urandom_range(0, 3));
      rs2_addr = 5'($urandom_range(0, 3));
      id_fence = ($urandom_range(0, 5) == 0);
      ex_valid = $urandom_range(0, 1);
      ex_load  = $urandom_range(0, 1);
      ex_rd    = 5'($urandom_range(0, 3));
      redirect = ($urandom_range(0, 9) == 0);
      busy     = $urandom_range(0, 1);
      @(negedge clk);
      checks++;
      if (obs_all() !== exp_all()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_all(), exp_all());
      end
      edge_adv();
    end
    rst_n = 1;
    set_idle();
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    #1;
    test_reset();
    test_load_use();
    test_redirect_hazard();
    test_fence();
    test_fence_busy();
    test_redirect_drain();
    test_reset_inv();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
